// File: rtl/gpr_file_p.sv
// General-purpose register file with two combinational read ports, optional write
// bypass, optional hardwired-zero r0 and a per-register pending (busy) scoreboard.
module gpr_file_p #(
  parameter int DW      = 8,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gpr_load,
  input  logic [AW-1:0] wr_sel,
  input  logic [DW-1:0] data_in,
  input  logic          lock_en,
  input  logic [AW-1:0] lock_sel,
  input  logic [AW-1:0] rd_sel,
  input  logic [AW-1:0] rs_sel,
  output logic [DW-1:0] rd_out,
  output logic [DW-1:0] rs_out,
  output logic          rd_busy,
  output logic          rs_busy,
  output logic          wr_conflict
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            wr_is_r0;

  assign wr_is_r0 = (ZERO_R0 != 0) && (wr_sel == '0);

  // A lock in the same cycle as a write to that register wins: the new producer owns it.
  always_comb begin
    busy_next = busy;
    if (gpr_load) busy_next[wr_sel] = 1'b0;
    if (lock_en) busy_next[lock_sel] = 1'b1;
    if (ZERO_R0 != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (gpr_load && !wr_is_r0) regs[wr_sel] <= data_in;
      busy        <= busy_next;
      wr_conflict <= gpr_load && !wr_is_r0 && !busy[wr_sel];
    end
  end

  function automatic logic [DW-1:0] read_data(input logic [AW-1:0] sel);
    if ((ZERO_R0 != 0) && (sel == '0)) return '0;
    if ((BYPASS != 0) && gpr_load && (sel == wr_sel)) return data_in;
    return regs[sel];
  endfunction

  // Under bypass the forwarded write has just produced the value, so only a fresh lock keeps it busy.
  function automatic logic read_busy(input logic [AW-1:0] sel);
    if ((ZERO_R0 != 0) && (sel == '0)) return 1'b0;
    if ((BYPASS != 0) && gpr_load && (sel == wr_sel)) return lock_en && (lock_sel == sel);
    return busy[sel];
  endfunction

  always_comb begin
    rd_out  = read_data(rd_sel);
    rs_out  = read_data(rs_sel);
    rd_busy = read_busy(rd_sel);
    rs_busy = read_busy(rs_sel);
  end

endmodule

// File: tb/tb_gpr_file_p.sv
// Bench for gpr_file_p: three configurations share one stimulus stream and are
// checked every cycle against an array model, plus hand-computed literal expectations.
module tb_gpr_file_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, gpr_load, lock_en;
  logic [4:0]  wr_sel, lock_sel, rd_sel, rs_sel;
  logic [15:0] data_in;

  logic [7:0]  a_rd, a_rs, b_rd, b_rs;
  logic [15:0] c_rd, c_rs;
  logic        a_rdb, a_rsb, a_conf, b_rdb, b_rsb, b_conf, c_rdb, c_rsb, c_conf;

  // a: defaults, b: hardwired r0 without bypass, c: wide and deep
  gpr_file_p u_a (
    .clk(clk), .rst(rst), .gpr_load(gpr_load), .wr_sel(wr_sel[2:0]), .data_in(data_in[7:0]),
    .lock_en(lock_en), .lock_sel(lock_sel[2:0]), .rd_sel(rd_sel[2:0]), .rs_sel(rs_sel[2:0]),
    .rd_out(a_rd), .rs_out(a_rs), .rd_busy(a_rdb), .rs_busy(a_rsb), .wr_conflict(a_conf)
  );

  gpr_file_p #(.ZERO_R0(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .gpr_load(gpr_load), .wr_sel(wr_sel[2:0]), .data_in(data_in[7:0]),
    .lock_en(lock_en), .lock_sel(lock_sel[2:0]), .rd_sel(rd_sel[2:0]), .rs_sel(rs_sel[2:0]),
    .rd_out(b_rd), .rs_out(b_rs), .rd_busy(b_rdb), .rs_busy(b_rsb), .wr_conflict(b_conf)
  );

  gpr_file_p #(.DW(16), .NREG(32)) u_c (
    .clk(clk), .rst(rst), .gpr_load(gpr_load), .wr_sel(wr_sel), .data_in(data_in),
    .lock_en(lock_en), .lock_sel(lock_sel), .rd_sel(rd_sel), .rs_sel(rs_sel),
    .rd_out(c_rd), .rs_out(c_rs), .rd_busy(c_rdb), .rs_busy(c_rsb), .wr_conflict(c_conf)
  );

  logic [15:0] d_rd [3];
  logic [15:0] d_rs [3];
  logic        d_rdb [3];
  logic        d_rsb [3];
  logic        d_conf [3];

  assign d_rd[0] = {8'h00, a_rd};
  assign d_rd[1] = {8'h00, b_rd};
  assign d_rd[2] = c_rd;
  assign d_rs[0] = {8'h00, a_rs};
  assign d_rs[1] = {8'h00, b_rs};
  assign d_rs[2] = c_rs;
  assign d_rdb[0] = a_rdb;
  assign d_rdb[1] = b_rdb;
  assign d_rdb[2] = c_rdb;
  assign d_rsb[0] = a_rsb;
  assign d_rsb[1] = b_rsb;
  assign d_rsb[2] = c_rsb;
  assign d_conf[0] = a_conf;
  assign d_conf[1] = b_conf;
  assign d_conf[2] = c_conf;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  logic [15:0] m_reg [3][32];
  bit          m_busy [3][32];
  bit          m_conf [3];

  function automatic bit cfg_zero(input int k);
    return k == 1;
  endfunction

  function automatic bit cfg_byp(input int k);
    return k != 1;
  endfunction

  function automatic logic [4:0] sel_mask(input int k);
    return (k == 2) ? 5'h1f : 5'h07;
  endfunction

  function automatic logic [15:0] data_mask(input int k);
    return (k == 2) ? 16'hffff : 16'h00ff;
  endfunction

  function automatic bit writes_r0(input int k);
    return cfg_zero(k) && ((wr_sel & sel_mask(k)) == 5'd0);
  endfunction

  function automatic logic [15:0] exp_data(input int k, input logic [4:0] sel);
    logic [4:0] s;
    s = sel & sel_mask(k);
    if (cfg_zero(k) && s == 5'd0) return 16'h0000;
    if (cfg_byp(k) && gpr_load && (wr_sel & sel_mask(k)) == s) return data_in & data_mask(k);
    return m_reg[k][s];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] sel);
    logic [4:0] s;
    s = sel & sel_mask(k);
    if (cfg_zero(k) && s == 5'd0) return 1'b0;
    if (cfg_byp(k) && gpr_load && (wr_sel & sel_mask(k)) == s)
      return lock_en && ((lock_sel & sel_mask(k)) == s);
    return m_busy[k][s];
  endfunction

  // Model state advances on each rising edge straight from the register-file rules.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_conf[k] <= 1'b0;
        for (int r = 0; r < 32; r++) begin
          m_reg[k][r]  <= 16'h0000;
          m_busy[k][r] <= 1'b0;
        end
      end else begin
        m_conf[k] <= gpr_load && !writes_r0(k) && !m_busy[k][wr_sel & sel_mask(k)];
        if (gpr_load && !writes_r0(k)) m_reg[k][wr_sel & sel_mask(k)] <= data_in & data_mask(k);
        for (int r = 0; r < 32; r++) begin
          if (lock_en && r == int'(lock_sel & sel_mask(k)) && !(cfg_zero(k) && r == 0))
            m_busy[k][r] <= 1'b1;
          else if (gpr_load && r == int'(wr_sel & sel_mask(k)))
            m_busy[k][r] <= 1'b0;
        end
      end
    end
    if (rst) armed <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("model rd_out[%0d]", k), d_rd[k], exp_data(k, rd_sel));
        checkOutput($sformatf("model rs_out[%0d]", k), d_rs[k], exp_data(k, rs_sel));
        checkOutput($sformatf("model rd_busy[%0d]", k), {15'h0, d_rdb[k]}, {15'h0, exp_busy(k, rd_sel)});
        checkOutput($sformatf("model rs_busy[%0d]", k), {15'h0, d_rsb[k]}, {15'h0, exp_busy(k, rs_sel)});
        checkOutput($sformatf("model wr_conflict[%0d]", k), {15'h0, d_conf[k]}, {15'h0, m_conf[k]});
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic ld, input logic [4:0] ws,
                               input logic [15:0] d, input logic lk, input logic [4:0] ls,
                               input logic [4:0] rds, input logic [4:0] rss);
    @(posedge clk);
    #1;
    rst      = r;
    gpr_load = ld;
    wr_sel   = ws;
    data_in  = d;
    lock_en  = lk;
    lock_sel = ls;
    rd_sel   = rds;
    rs_sel   = rss;
  endtask

  initial begin
    rst = 1'b1; gpr_load = 1'b0; lock_en = 1'b0;
    wr_sel = 5'd0; lock_sel = 5'd0; rd_sel = 5'd0; rs_sel = 5'd0; data_in = 16'h0000;

    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3, 7);
    @(negedge clk);
    checkOutput("reset rd_out", {8'h0, a_rd}, 16'h0000);
    checkOutput("reset rs_out", {8'h0, a_rs}, 16'h0000);
    checkOutput("reset rd_busy", {15'h0, a_rdb}, 16'h0000);
    checkOutput("reset wr_conflict", {15'h0, a_conf}, 16'h0000);

    // two writes, conflict pulse after each
    applyStimulus(0, 1, 3, 16'h00A5, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 16'h003C, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("conflict after r3", {15'h0, a_conf}, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3, 7);
    @(negedge clk);
    checkOutput("read r3", {8'h0, a_rd}, 16'h00A5);
    checkOutput("read r7", {8'h0, a_rs}, 16'h003C);
    checkOutput("conflict after r7", {15'h0, a_conf}, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3, 7);
    @(negedge clk);
    checkOutput("conflict drops", {15'h0, a_conf}, 16'h0000);

    // bypass versus no bypass
    applyStimulus(0, 1, 5, 16'h0077, 0, 0, 5, 0);
    @(negedge clk);
    checkOutput("bypass rd_out", {8'h0, a_rd}, 16'h0077);
    checkOutput("no-bypass rd_out", {8'h0, b_rd}, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 5, 0);
    @(negedge clk);
    checkOutput("no-bypass next cycle", {8'h0, b_rd}, 16'h0077);

    // scoreboard lock, release, and lock+write ownership
    applyStimulus(0, 0, 0, 16'h0000, 1, 2, 2, 0);
    @(negedge clk);
    checkOutput("lock not yet visible", {15'h0, a_rdb}, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 2, 0);
    @(negedge clk);
    checkOutput("r2 busy", {15'h0, a_rdb}, 16'h0001);
    applyStimulus(0, 1, 2, 16'h0011, 0, 0, 2, 0);
    @(negedge clk);
    checkOutput("bypass busy clear", {15'h0, a_rdb}, 16'h0000);
    checkOutput("no-bypass busy held", {15'h0, b_rdb}, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 2, 0);
    @(negedge clk);
    checkOutput("r2 released", {15'h0, a_rdb}, 16'h0000);
    checkOutput("no conflict on pending", {15'h0, a_conf}, 16'h0000);
    applyStimulus(0, 1, 2, 16'h0011, 1, 2, 2, 0);
    @(negedge clk);
    checkOutput("bypass lock+write busy", {15'h0, a_rdb}, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 2, 0);
    @(negedge clk);
    checkOutput("lock+write busy kept", {15'h0, a_rdb}, 16'h0001);
    checkOutput("lock+write data", {8'h0, a_rd}, 16'h0011);
    checkOutput("lock+write conflict", {15'h0, a_conf}, 16'h0001);

    // hardwired r0
    applyStimulus(0, 1, 0, 16'h00FF, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0 bypass zero", {8'h0, b_rd}, 16'h0000);
    checkOutput("r0 bypass normal", {8'h0, a_rd}, 16'h00FF);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0 stays zero", {8'h0, b_rd}, 16'h0000);
    checkOutput("r0 no conflict", {15'h0, b_conf}, 16'h0000);
    checkOutput("r0 normal conflict", {15'h0, a_conf}, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0000, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0 lock ignored", {15'h0, b_rdb}, 16'h0000);
    checkOutput("r0 lock normal", {15'h0, a_rdb}, 16'h0001);

    // reset discards pending locks and overrides a write
    applyStimulus(0, 0, 0, 16'h0000, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 16'h0000, 1, 4, 0, 0);
    applyStimulus(0, 1, 6, 16'h005A, 0, 0, 1, 4);
    @(negedge clk);
    checkOutput("r1 pending", {15'h0, a_rdb}, 16'h0001);
    checkOutput("r4 pending", {15'h0, a_rsb}, 16'h0001);
    applyStimulus(1, 1, 6, 16'h0099, 1, 3, 1, 4);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 6);
    @(negedge clk);
    checkOutput("post-reset rd_busy", {15'h0, a_rdb}, 16'h0000);
    checkOutput("post-reset r6", {8'h0, a_rs}, 16'h0000);
    checkOutput("post-reset conflict", {15'h0, a_conf}, 16'h0000);
    checkOutput("post-reset r1", {8'h0, a_rd}, 16'h0000);

    // wide/deep instance: fill and read back all registers
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 1, 5'(i), 16'(i) ^ 16'hBEEF, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 16'h0000, 0, 0, 5'(i), 5'(31 - i));
      @(negedge clk);
      checkOutput($sformatf("wide rd r%0d", i), c_rd, 16'(i) ^ 16'hBEEF);
      checkOutput($sformatf("wide rs r%0d", 31 - i), c_rs, 16'(31 - i) ^ 16'hBEEF);
    end
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 9, 9);
    @(negedge clk);
    checkOutput("same-select rd", c_rd, 16'hBEE6);
    checkOutput("same-select rs", c_rs, 16'hBEE6);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_p.md
GPR_FILE_P -- requirements
Module: gpr_file_p

Interface
REQ-001 SHALL provide parameter DW, default 8, meaning register data width in bits (legal range 1..64).
REQ-002 SHALL provide parameter NREG, default 8, meaning number of registers (power of two, 2..32).
REQ-003 SHALL provide parameter AW, default $clog2(NREG), meaning register select width.
REQ-004 SHALL provide parameter ZERO_R0, default 0, meaning that when 1, register 0 is hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1, meaning that when 1, same-cycle write data is forwarded to the read ports.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 gpr_load  input  1  write enable.
REQ-010 wr_sel  input  AW  write register select.
REQ-011 data_in  input  DW  write data.
REQ-012 lock_en  input  1  mark register lock_sel as pending (scoreboard set).
REQ-013 lock_sel  input  AW  register to mark pending.
REQ-014 rd_sel  input  AW  read port A select.
REQ-015 rs_sel  input  AW  read port B select.
REQ-016 rd_out  output  DW  read port A data.
REQ-017 rs_out  output  DW  read port B data.
REQ-018 rd_busy  output  1  pending flag of register rd_sel.
REQ-019 rs_busy  output  1  pending flag of register rs_sel.
REQ-020 wr_conflict  output  1  registered one-cycle pulse: write targeted a register not marked pending.

Function
REQ-021 SHALL hold NREG registers of DW bits and one busy bit per register.
REQ-022 On a rising clk edge with gpr_load=1, register wr_sel SHALL take data_in; all other registers SHALL hold.
REQ-023 Read ports SHALL be combinational: rd_out = reg[rd_sel] and rs_out = reg[rs_sel], with zero latency, independent of each other.
REQ-024 With BYPASS=1, gpr_load=1 and wr_sel equal to a read select, that port SHALL output data_in in the same cycle; with BYPASS=0 it SHALL output the old value until the next edge.
REQ-025 With ZERO_R0=1, writes to register 0 SHALL be discarded, reads of register 0 SHALL return 0 (including under bypass), and busy[0] SHALL never set.
REQ-026 lock_en=1 SHALL set busy[lock_sel] at the next edge.
REQ-027 gpr_load=1 SHALL clear busy[wr_sel] at the next edge.
REQ-028 Simultaneous lock_en and gpr_load to the same register SHALL leave busy set, with the data written (the new producer takes ownership).
REQ-029 Simultaneous lock_en and gpr_load to different registers SHALL apply both.
REQ-030 rd_busy/rs_busy SHALL reflect busy of the selected register, combinationally from state.
REQ-031 With BYPASS=1, a port whose select equals wr_sel during gpr_load SHALL report busy=0 unless lock_en targets the same register in that cycle.
REQ-032 wr_conflict SHALL be 1 for exactly the cycle after a gpr_load to a register whose busy was 0 (excluding register 0 when ZERO_R0=1), and 0 otherwise.
REQ-033 Out-of-range selects cannot occur, because NREG is a power of two; all select values SHALL be decoded.

Reset
REQ-034 rst=1 at a rising edge SHALL clear all registers to 0, all busy bits to 0 and wr_conflict to 0, overriding gpr_load and lock_en in that cycle.
REQ-035 After reset, rd_out=rs_out=0, rd_busy=rs_busy=0 and wr_conflict=0 SHALL hold until the first write or lock.
REQ-036 Reset asserted during pending locks SHALL discard them, and no wr_conflict SHALL result from the reset itself.

Verification
REQ-037 Reset, then write 8'hA5 to r3 and 8'h3C to r7; set rd_sel=3, rs_sel=7 -> rd_out=A5, rs_out=3C; wr_conflict pulses after each write.
REQ-038 BYPASS=1: gpr_load=1, wr_sel=5, data_in=8'h77, rd_sel=5, with old value 0 -> rd_out=77 in the same cycle; BYPASS=0 -> rd_out=00, then 77 next cycle.
REQ-039 lock r2; next cycle rd_sel=2 -> rd_busy=1; write r2=8'h11 -> busy cleared after the edge, wr_conflict=0; same cycle lock+write r2 -> busy stays 1, data=11.
REQ-040 ZERO_R0=1: write 8'hFF to r0 -> rd_out=00, busy[0]=0, no wr_conflict; lock r0 -> rd_busy stays 0.
REQ-041 Lock r1 and r4, write r6=8'h5A, then assert rst with gpr_load=1 -> all reads 0, all busy 0, wr_conflict=0 next cycle.
REQ-042 DW=16, NREG=32: write every register with its index XOR 16'hBEEF, then read all pairs -> every value matches; rd_sel=rs_sel returns the same value on both ports.
